// File: rtl/cpu7_ifu_de_pipe.sv
// rtl/cpu7_ifu_de_pipe.sv - fetch-to-decode pipeline register with optional skid entry
//
// Optional feature: define CPU7_IFU_DE_SKID_EN to build the two-entry
// (output + skid) variant with a registered ifu_ready. Without it the stage
// is a single output register with a combinational ifu_ready.

`ifndef LSOC1K_DECODE_RES_BIT
`define LSOC1K_DECODE_RES_BIT 64
`endif

module cpu7_ifu_de_pipe #(
  parameter int GRLEN = 32
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              flush,
  input  logic                              ifu_valid,
  output logic                              ifu_ready,
  input  logic [GRLEN-1:0]                  ifu_pc,
  input  logic [31:0]                       ifu_inst,
  input  logic [`LSOC1K_DECODE_RES_BIT-1:0] ifu_op,
  input  logic [31:0]                       ifu_imm,
  input  logic [GRLEN-1:0]                  ifu_alu_c,
  input  logic [GRLEN-1:0]                  ifu_br_offs,
  output logic                              de_valid,
  input  logic                              de_ready,
  output logic [GRLEN-1:0]                  de_pc,
  output logic [31:0]                       de_inst,
  output logic [`LSOC1K_DECODE_RES_BIT-1:0] de_op,
  output logic [31:0]                       de_imm,
  output logic [GRLEN-1:0]                  de_alu_c,
  output logic [GRLEN-1:0]                  de_br_target,
  output logic                              de_adef,
  output logic [1:0]                        de_occ
);

  localparam int OPW = `LSOC1K_DECODE_RES_BIT;

  // One held instruction; target and adef are resolved at capture time.
  typedef struct packed {
    logic [GRLEN-1:0] pc;
    logic [31:0]      inst;
    logic [OPW-1:0]   op;
    logic [31:0]      imm;
    logic [GRLEN-1:0] alu_c;
    logic [GRLEN-1:0] tgt;
    logic             adef;
  } ent_t;

  ent_t in_ent;
  ent_t out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic rdy_q, rdy_d;
  logic accept, consume;

  // Build the incoming entry; branch target wraps modulo 2^GRLEN.
  always_comb begin
    in_ent       = '0;
    in_ent.pc    = ifu_pc;
    in_ent.inst  = ifu_inst;
    in_ent.op    = ifu_op;
    in_ent.imm   = ifu_imm;
    in_ent.alu_c = ifu_alu_c;
    in_ent.tgt   = ifu_pc + ifu_br_offs;
    in_ent.adef  = |ifu_pc[1:0];
  end

  assign accept  = ifu_valid & ifu_ready & ~flush;
  assign consume = out_valid_q & de_ready & ~flush;

  assign de_valid     = out_valid_q;
  assign de_pc        = out_q.pc;
  assign de_inst      = out_q.inst;
  assign de_op        = out_q.op;
  assign de_imm       = out_q.imm;
  assign de_alu_c     = out_q.alu_c;
  assign de_br_target = out_q.tgt;
  assign de_adef      = out_q.adef;

`ifdef CPU7_IFU_DE_SKID_EN

  ent_t skid_q, skid_d;
  logic skid_valid_q, skid_valid_d;

  // Next state: a consume refills the output from skid; a stalled accept lands in skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (consume) begin
        if (skid_valid_q) begin
          out_d        = skid_q;
          skid_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b0;
        end
      end
      // ifu_ready is low whenever skid is occupied, so accept never collides with a skid refill.
      if (accept) begin
        if (!out_valid_q || consume) begin
          out_d       = in_ent;
          out_valid_d = 1'b1;
        end else begin
          skid_d       = in_ent;
          skid_valid_d = 1'b1;
        end
      end
    end
    rdy_d = ~skid_valid_d;
  end

  // Skid entry storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign ifu_ready = rdy_q;
  assign de_occ    = {1'b0, out_valid_q} + {1'b0, skid_valid_q};

`else

  // Next state: single register loads on accept, empties on consume or flush.
  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_d       = in_ent;
      out_valid_d = 1'b1;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end
    rdy_d = 1'b1;
  end

  // rdy_q only holds ready low until the first edge after reset release.
  assign ifu_ready = rdy_q & (~out_valid_q | de_ready);
  assign de_occ    = {1'b0, out_valid_q};

`endif

  // Output register and ready flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
      rdy_q       <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      rdy_q       <= rdy_d;
    end
  end

endmodule

// File: tb/tb_cpu7_ifu_de_pipe.sv
// tb/tb_cpu7_ifu_de_pipe.sv - randomized queue-model bench for cpu7_ifu_de_pipe

`ifndef LSOC1K_DECODE_RES_BIT
`define LSOC1K_DECODE_RES_BIT 64
`endif

module tb_cpu7_ifu_de_pipe;

  localparam int GRLEN = 32;
  localparam int OPW   = `LSOC1K_DECODE_RES_BIT;
`ifdef CPU7_IFU_DE_SKID_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  logic             clk;
  logic             resetn;
  logic             flush;
  logic             ifu_valid;
  logic             ifu_ready;
  logic [GRLEN-1:0] ifu_pc;
  logic [31:0]      ifu_inst;
  logic [OPW-1:0]   ifu_op;
  logic [31:0]      ifu_imm;
  logic [GRLEN-1:0] ifu_alu_c;
  logic [GRLEN-1:0] ifu_br_offs;
  logic             de_valid;
  logic             de_ready;
  logic [GRLEN-1:0] de_pc;
  logic [31:0]      de_inst;
  logic [OPW-1:0]   de_op;
  logic [31:0]      de_imm;
  logic [GRLEN-1:0] de_alu_c;
  logic [GRLEN-1:0] de_br_target;
  logic             de_adef;
  logic [1:0]       de_occ;

  int total = 0;
  int bad   = 0;

  cpu7_ifu_de_pipe #(.GRLEN(GRLEN)) dut (
    .clk(clk), .resetn(resetn), .flush(flush),
    .ifu_valid(ifu_valid), .ifu_ready(ifu_ready),
    .ifu_pc(ifu_pc), .ifu_inst(ifu_inst), .ifu_op(ifu_op), .ifu_imm(ifu_imm),
    .ifu_alu_c(ifu_alu_c), .ifu_br_offs(ifu_br_offs),
    .de_valid(de_valid), .de_ready(de_ready),
    .de_pc(de_pc), .de_inst(de_inst), .de_op(de_op), .de_imm(de_imm),
    .de_alu_c(de_alu_c), .de_br_target(de_br_target), .de_adef(de_adef),
    .de_occ(de_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [GRLEN-1:0] pc;
    logic [31:0]      inst;
    logic [OPW-1:0]   op;
    logic [31:0]      imm;
    logic [GRLEN-1:0] alu_c;
    logic [GRLEN-1:0] tgt;
    logic             adef;
  } ent_t;

  ent_t q[$];
  bit   up;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_ready();
    if (!up) return 1'b0;
    if (DEPTH == 2) return q.size() < 2;
    return (q.size() == 0) || de_ready;
  endfunction

  // Reference model: a FIFO of at most DEPTH entries.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      q.delete();
      up = 1'b0;
    end else begin
      bit   acc;
      bit   con;
      ent_t e;
      acc = ifu_valid && m_ready() && !flush;
      con = (q.size() > 0) && de_ready && !flush;
      if (flush) begin
        q.delete();
      end else begin
        if (con) void'(q.pop_front());
        if (acc) begin
          e.pc    = ifu_pc;
          e.inst  = ifu_inst;
          e.op    = ifu_op;
          e.imm   = ifu_imm;
          e.alu_c = ifu_alu_c;
          e.tgt   = ifu_pc + ifu_br_offs;
          e.adef  = (ifu_pc % 4) != 0;
          q.push_back(e);
        end
      end
      up = 1'b1;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (!resetn) begin
      chk("rst_valid", 128'(de_valid), 128'(0));
      chk("rst_occ", 128'(de_occ), 128'(0));
      chk("rst_pc", 128'(de_pc), 128'(0));
      chk("rst_tgt", 128'(de_br_target), 128'(0));
    end else begin
      chk("ifu_ready", 128'(ifu_ready), 128'(m_ready()));
      chk("de_valid", 128'(de_valid), 128'(q.size() > 0));
      chk("de_occ", 128'(de_occ), 128'(q.size()));
      if (q.size() > 0) begin
        chk("de_pc", 128'(de_pc), 128'(q[0].pc));
        chk("de_inst", 128'(de_inst), 128'(q[0].inst));
        chk("de_op", 128'(de_op), 128'(q[0].op));
        chk("de_imm", 128'(de_imm), 128'(q[0].imm));
        chk("de_alu_c", 128'(de_alu_c), 128'(q[0].alu_c));
        chk("de_br_target", 128'(de_br_target), 128'(q[0].tgt));
        chk("de_adef", 128'(de_adef), 128'(q[0].adef));
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input bit v, input logic [31:0] pc, input logic [31:0] offs);
    ifu_valid   = v;
    ifu_pc      = pc;
    ifu_br_offs = offs;
    ifu_inst    = $urandom;
    ifu_imm     = $urandom;
    ifu_alu_c   = $urandom;
    for (int i = 0; i < OPW; i++) ifu_op[i] = 1'($urandom_range(1, 0));
  endtask

  initial begin
    resetn    = 1'b0;
    flush     = 1'b0;
    de_ready  = 1'b0;
    set_in(1'b0, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b1;
    cyc();
    chk("ready_after_reset", 128'(ifu_ready), 128'(1));
    cyc();

    // Pass-through
    de_ready = 1'b1;
    set_in(1'b1, 32'h1000, 32'h40);
    cyc();
    chk("pt_valid", 128'(de_valid), 128'(1));
    chk("pt_tgt", 128'(de_br_target), 128'(32'h1040));
    chk("pt_adef", 128'(de_adef), 128'(0));
    chk("pt_occ", 128'(de_occ), 128'(1));
    ifu_valid = 1'b0;
    cyc();
    chk("pt_drain", 128'(de_valid), 128'(0));

    // Target wrap
    set_in(1'b1, 32'hFFFF_FFFC, 32'h8);
    cyc();
    chk("wrap_tgt", 128'(de_br_target), 128'(32'h4));
    ifu_valid = 1'b0;
    cyc();

    // Misaligned pc
    set_in(1'b1, 32'h1002, 32'h20);
    cyc();
    chk("mis_valid", 128'(de_valid), 128'(1));
    chk("mis_adef", 128'(de_adef), 128'(1));
    chk("mis_tgt", 128'(de_br_target), 128'(32'h1022));
    ifu_valid = 1'b0;
    cyc();

    // Stall with two back-to-back entries
    de_ready = 1'b0;
    set_in(1'b1, 32'hA000, 32'h4);
    cyc();
    chk("st_a_pc", 128'(de_pc), 128'(32'hA000));
    chk("st_a_occ", 128'(de_occ), 128'(1));
`ifdef CPU7_IFU_DE_SKID_EN
    set_in(1'b1, 32'hB000, 32'h4);
    cyc();
    chk("st_b_occ", 128'(de_occ), 128'(2));
    chk("st_b_ready", 128'(ifu_ready), 128'(0));
    chk("st_b_pc", 128'(de_pc), 128'(32'hA000));
    ifu_valid = 1'b0;
    cyc();
    chk("st_hold_pc", 128'(de_pc), 128'(32'hA000));
    de_ready = 1'b1;
    cyc();
    chk("st_next_pc", 128'(de_pc), 128'(32'hB000));
    chk("st_next_ready", 128'(ifu_ready), 128'(1));
    chk("st_next_occ", 128'(de_occ), 128'(1));
`else
    chk("st_a_ready", 128'(ifu_ready), 128'(0));
    set_in(1'b1, 32'hB000, 32'h4);
    cyc();
    chk("st_hold_pc", 128'(de_pc), 128'(32'hA000));
    chk("st_hold_occ", 128'(de_occ), 128'(1));
    de_ready = 1'b1;
    #1;
    chk("st_comb_ready", 128'(ifu_ready), 128'(1));
    cyc();
    chk("st_next_pc", 128'(de_pc), 128'(32'hB000));
    chk("st_next_occ", 128'(de_occ), 128'(1));
    ifu_valid = 1'b0;
`endif
    cyc();
    chk("st_empty", 128'(de_valid), 128'(0));

    // Flush with storage full and an incoming entry
    de_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'hC000 + 32'(i * 4), 32'h0);
      cyc();
    end
    chk("fl_full", 128'(de_occ), 128'(DEPTH));
    flush = 1'b1;
    set_in(1'b1, 32'hD000, 32'h0);
    cyc();
    chk("fl_valid", 128'(de_valid), 128'(0));
    chk("fl_occ", 128'(de_occ), 128'(0));
    flush     = 1'b0;
    ifu_valid = 1'b0;
    cyc();
    chk("fl_no_capture", 128'(de_valid), 128'(0));

    // Reset mid-stall
    for (int i = 0; i < DEPTH; i++) begin
      set_in(1'b1, 32'hE000 + 32'(i * 4), 32'h0);
      cyc();
    end
    ifu_valid = 1'b0;
    chk("rs_full", 128'(de_occ), 128'(DEPTH));
    #2 resetn = 1'b0;
    #1;
    chk("rs_valid", 128'(de_valid), 128'(0));
    chk("rs_occ", 128'(de_occ), 128'(0));
    chk("rs_pc", 128'(de_pc), 128'(0));
    repeat (2) cyc();
    resetn = 1'b1;
    cyc();
    chk("rs_ready", 128'(ifu_ready), 128'(1));
    chk("rs_no_stale", 128'(de_valid), 128'(0));
    de_ready = 1'b1;
    cyc();
    chk("rs_no_stale2", 128'(de_valid), 128'(0));

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      flush    = ($urandom_range(99) < 3);
      de_ready = ($urandom_range(99) < 55);
      set_in($urandom_range(99) < 70, $urandom, $urandom);
      cyc();
    end
    flush     = 1'b0;
    ifu_valid = 1'b0;
    de_ready  = 1'b1;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu7_ifu_de_pipe.md
CPU7_IFU_DE_PIPE -- requirements
Module: cpu7_ifu_de_pipe

Interface
REQ-001 SHALL have parameter: GRLEN, 32, datapath width of pc, immediate, alu_c and target.
REQ-002 SHALL have ports in this order (clock and reset first; one clock; reset is asynchronous and active-low):
  clk  in  1  sole clock, rising edge
  resetn  in  1  asynchronous active-low reset
  flush  in  1  kill every held entry and block acceptance this cycle
  ifu_valid  in  1  upstream entry valid
  ifu_ready  out  1  stage can accept an entry
  ifu_pc  in  GRLEN  pc of the instruction
  ifu_inst  in  32  raw instruction
  ifu_op  in  `LSOC1K_DECODE_RES_BIT  decoded op vector
  ifu_imm  in  32  shifted immediate from the immediate decoder
  ifu_alu_c  in  GRLEN  alu third operand from the immediate decoder
  ifu_br_offs  in  GRLEN  branch offset from the immediate decoder
  de_valid  out  1  entry presented to execute
  de_ready  in  1  execute consumes entry
  de_pc, de_inst, de_op, de_imm, de_alu_c  out  as inputs  registered copies
  de_br_target  out  GRLEN  ifu_pc + ifu_br_offs
  de_adef  out  1  ifu_pc[1:0] != 0
  de_occ  out  2  entries held (0..2)

Function
REQ-003 SHALL accept an entry when ifu_valid & ifu_ready & !flush.
REQ-004 SHALL consume the output entry when de_valid & de_ready & !flush.
REQ-005 SHALL compute de_br_target as GRLEN-bit sum modulo 2^GRLEN at capture; carry-out discarded (0xFFFFFFFC + 8 = 0x00000004).
REQ-006 SHALL compute de_adef at capture from ifu_pc[1:0]; entry still passes normally.
REQ-007 SHALL present a newly accepted entry on de_* exactly one cycle after acceptance when the output register is empty or being consumed.
REQ-008 SHALL preserve acceptance order; no entry duplicated or dropped except by flush.
REQ-009 SHALL hold all de_* stable while de_valid & !de_ready & !flush.
REQ-010 SHALL, on flush, clear de_valid and every held entry at the next edge, ignore ifu_valid and de_ready that cycle, set de_occ=0.
REQ-011 SHALL keep de_occ equal to held entries; simultaneous accept and consume leaves it unchanged.
REQ-012 SHALL drive ifu_ready from a flop (no combinational path from de_ready) when the skid option is built.

Reset
REQ-013 SHALL, while resetn=0, asynchronously force de_valid=0, de_occ=0, all de_* data 0, skid entry invalid.
REQ-014 SHALL drive ifu_ready=1 from the first edge after resetn rises.
REQ-015 SHALL discard any in-flight entry when reset asserts mid-operation; none reappears after release.

Configuration
REQ-016 SHALL use macro CPU7_IFU_DE_SKID_EN.
REQ-017 With CPU7_IFU_DE_SKID_EN defined: two-entry storage (output register + skid register); ifu_ready = !skid_valid (registered); entry accepted while output stalled goes to skid; on consume skid moves to output; de_occ reaches 2.
REQ-018 Without it: single output register; ifu_ready = !de_valid | de_ready (combinational); de_occ max 1; all other requirements unchanged.

Verification
REQ-019 Pass-through: pc=0x1000, br_offs=0x40, de_ready=1 -> next cycle de_valid=1, de_br_target=0x1040, de_adef=0, de_occ=1.
REQ-020 Wrap: pc=0xFFFFFFFC, br_offs=0x8 -> de_br_target=0x00000004.
REQ-021 Stall (skid build): de_ready=0, two back-to-back entries A,B -> de_occ=2, ifu_ready=0, de_* stays A; de_ready=1 -> A then B on consecutive cycles, ifu_ready=1 one cycle after A consumed.
REQ-022 Flush with de_occ=2 and ifu_valid=1 -> next cycle de_valid=0, de_occ=0, incoming entry not captured.
REQ-023 Misaligned pc=0x1002 -> de_adef=1, entry delivered with de_br_target = 0x1002 + br_offs.
REQ-024 resetn pulsed low mid-stall with de_occ=2 -> outputs 0 immediately; after release no stale entry, ifu_ready=1.
